// File: rtl/x_23k640_slave.sv
// rtl/x_23k640_slave.sv - oversampled SPI slave modelling a 23K640-style SRAM (optional X_23K640_SLAVE_SYNC_EN)
// SPI pins are sampled on i_clk; SCK edges are found against a registered copy of SCK.
module x_23k640_slave #(
  parameter int ADDR_W = 13,
  parameter int PAGE_W = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cs,
  input  logic       i_sck,
  input  logic       i_si,
  output logic       o_so,
  output logic [7:0] o_status
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, WRSR, IGNORE
  } state_t;

  logic cs_s, sck_s, si_s;

`ifdef X_23K640_SLAVE_SYNC_EN
  logic [1:0] cs_ff, sck_ff, si_ff;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_ff  <= 2'b11;
      sck_ff <= 2'b00;
      si_ff  <= 2'b00;
    end else begin
      cs_ff  <= {cs_ff[0], i_cs};
      sck_ff <= {sck_ff[0], i_sck};
      si_ff  <= {si_ff[0], i_si};
    end
  end
  assign cs_s  = cs_ff[1];
  assign sck_s = sck_ff[1];
  assign si_s  = si_ff[1];
`else
  assign cs_s  = i_cs;
  assign sck_s = i_sck;
  assign si_s  = i_si;
`endif

  state_t            state, state_nx;
  logic              sck_q, cs_q;
  logic [2:0]        bit_cnt;
  logic [3:0]        abit_cnt;
  logic [7:0]        rx_sr, tx_sr, status;
  logic [ADDR_W-1:0] addr;
  logic              rd_flag, done, so;
  logic [7:0]        mem [0:(2**ADDR_W)-1];

  logic       sck_rise, sck_fall, cs_fall;
  logic [7:0] rx_byte, rd_byte;
  logic       wr_en;

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign cs_fall  = cs_q & ~cs_s;
  assign rx_byte  = {rx_sr[6:0], si_s};
  assign rd_byte  = (state == RDSR) ? status : (done ? 8'h00 : mem[addr]);
  assign wr_en    = ~cs_s && (state == WR_DATA) && sck_rise && (bit_cnt == 3'd7) && !done;

  // Page mode wraps within the low PAGE_W bits; sequential wraps over the whole array.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] m);
    logic [ADDR_W-1:0] n;
    n = a + 1'b1;
    if (m == 2'b10)
      n = {a[ADDR_W-1:PAGE_W], a[PAGE_W-1:0] + {{(PAGE_W-1){1'b0}}, 1'b1}};
    return n;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cs_fall) state_nx = CMD;
      CMD: if (sck_rise && bit_cnt == 3'd7) begin
        case (rx_byte)
          8'h03, 8'h02: state_nx = ADDR;
          8'h05:        state_nx = RDSR;
          8'h01:        state_nx = WRSR;
          default:      state_nx = IGNORE;
        endcase
      end
      ADDR: if (sck_rise && abit_cnt == 4'd15) state_nx = rd_flag ? RD_DATA : WR_DATA;
      default: state_nx = state;
    endcase
    if (cs_s) state_nx = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      bit_cnt  <= 3'd0;
      abit_cnt <= 4'd0;
      rx_sr    <= 8'h00;
      tx_sr    <= 8'h00;
      status   <= 8'h00;
      addr     <= '0;
      rd_flag  <= 1'b0;
      done     <= 1'b0;
      so       <= 1'b0;
    end else begin
      sck_q <= sck_s;
      cs_q  <= cs_s;
      if (cs_s || state == IDLE || state == IGNORE) begin
        bit_cnt  <= 3'd0;
        abit_cnt <= 4'd0;
        done     <= 1'b0;
        so       <= 1'b0;
      end else begin
        case (state)
          CMD: if (sck_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            rd_flag <= (rx_byte == 8'h03);
          end
          ADDR: if (sck_rise) begin
            addr     <= {addr[ADDR_W-2:0], si_s};
            abit_cnt <= abit_cnt + 4'd1;
          end
          RD_DATA, RDSR: if (sck_fall) begin
            // A new byte is fetched on the first falling edge of each byte slot.
            if (bit_cnt == 3'd0) begin
              so    <= rd_byte[7];
              tx_sr <= {rd_byte[6:0], 1'b0};
            end else begin
              so    <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
            bit_cnt <= bit_cnt + 3'd1;
            if (state == RD_DATA && bit_cnt == 3'd7) begin
              if (status[7:6] == 2'b01 || status[7:6] == 2'b10) addr <= next_addr(addr, status[7:6]);
              else done <= 1'b1;
            end
          end
          WR_DATA: if (sck_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (status[7:6] == 2'b01 || status[7:6] == 2'b10) addr <= next_addr(addr, status[7:6]);
              else done <= 1'b1;
            end
          end
          WRSR: if (sck_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && !done) begin
              status <= {rx_byte[7:6], 5'b00000, rx_byte[0]};
              done   <= 1'b1;
            end
          end
          default: so <= 1'b0;
        endcase
      end
    end
  end

  // Array has no reset so committed bytes survive i_rst.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[addr] <= rx_byte;
  end

  assign o_so     = so;
  assign o_status = status;

endmodule

// File: doc/x_23k640_slave.md
X_23K640_SLAVE -- requirements
Module: x_23K640_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, number of implemented array address bits (2^ADDR_W bytes).
REQ-002 SHALL have parameter PAGE_W, default 5, page size 2^PAGE_W bytes for page mode.
REQ-003 SHALL have port i_clk  input  1  system clock, oversamples all SPI signals.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_cs  input  1  SPI chip select, active-low.
REQ-006 SHALL have port i_sck  input  1  SPI clock, mode 0.
REQ-007 SHALL have port i_si  input  1  SPI serial data in (MOSI).
REQ-008 SHALL have port o_so  output  1  SPI serial data out (MISO); 0 when not driving.
REQ-009 SHALL have port o_status  output  8  current status register.

Function
REQ-010 SHALL detect SCK rising and falling edges against a registered copy of i_sck (post-synchroniser when enabled).
REQ-011 SHALL sample i_si on SCK rising edges; SHALL update o_so on SCK falling edges; bits MSB first.
REQ-012 SHALL use FSM states IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, WRSR, IGNORE, with a 3-bit bit counter and a 4-bit address bit counter.
REQ-013 SHALL go IDLE->CMD on i_cs falling; i_cs high SHALL force IDLE from any state within one cycle, o_so=0.
REQ-014 After 8 CMD bits: 0x03->ADDR(read), 0x02->ADDR(write), 0x05->RDSR, 0x01->WRSR, any other->IGNORE.
REQ-015 ADDR SHALL capture 16 address bits; only bits [ADDR_W-1:0] address the array, upper bits ignored.
REQ-016 Read: first data bit SHALL be on o_so after the SCK falling edge following the 16th address bit; subsequent bits on each falling edge.
REQ-017 Write: on the 8th rising edge of a data byte, the byte SHALL be written to the array at the current address in the same cycle.
REQ-018 Address advance after each byte: mode 00 (byte) no further bytes (read then drives 0, writes discarded); mode 10 (page) increment low PAGE_W bits only, wrap in page; mode 01 (sequential) increment mod 2^ADDR_W; mode 11 treated as byte.
REQ-019 RDSR SHALL shift out the status register repeatedly until CS high.
REQ-020 WRSR SHALL load status on the 8th data bit; only bits [7:6] and [0] writable, others read 0; later bits ignored.
REQ-021 CS rising mid-byte SHALL discard the partial byte; array and status unchanged by it.
REQ-022 IGNORE SHALL hold o_so=0 and accept no writes until CS high.
REQ-023 SCK edges while i_cs high SHALL be ignored.

Reset
REQ-024 On i_rst: state IDLE, counters 0, status 0x00, o_so 0, o_status 0x00.
REQ-025 Array contents SHALL NOT be reset; reset mid-write SHALL not corrupt already committed bytes.

Configuration
REQ-026 Macro X_23K640_SLAVE_SYNC_EN defined: i_cs, i_sck, i_si SHALL each pass through a 2-flop synchroniser (reset value cs=1, others 0) before use, adding 2 i_clk latency.
REQ-027 Macro undefined: inputs used directly (same clock domain), no added latency; functional behaviour otherwise identical.

Verification
REQ-028 WRSR 0x01,0x41 -> o_status=0x41; RDSR -> o_so shifts 0x41 repeatedly.
REQ-029 Sequential mode, WRITE 0x02 addr 0x0010 data 0xA5,0x5A; READ 0x03 addr 0x0010 two bytes -> 0xA5,0x5A.
REQ-030 Page mode (status 0x81), WRITE addr 0x001F data 0x11,0x22 -> mem[0x1F]=0x11, mem[0x00]=0x22.
REQ-031 Byte mode (reset), WRITE addr 0x0003 data 0x77,0x88 -> mem[3]=0x77, mem[4] unchanged; read of 2 bytes -> 0x77,0x00.
REQ-032 WRITE addr 0x0005, CS high after 5 data bits -> mem[5] unchanged; next command decodes normally.
REQ-033 Command 0x9F -> o_so=0 throughout; sequential READ at 0x1FFF (ADDR_W=13) for 2 bytes -> mem[0x1FFF], mem[0x0000].
